// File: rtl/bp_pkg.sv
// Branch predictor shared definitions.
// Contents: the 2-bit saturating counter encoding and default sizing constants.
package bp_pkg;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 64;

  // Bit 1 of the counter is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating branch counter.
// Ports:
//   state_i  current counter state
//   taken_i  resolved outcome (1 = taken)
//   next_o   next counter state, clamped at ST and SNT
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_cnt_e state_i,
  input  logic    taken_i,
  output bp_cnt_e next_o
);

  always_comb begin
    next_o = state_i;
    if (taken_i) begin
      if (state_i != ST) next_o = bp_cnt_e'(state_i + 2'd1);
    end else begin
      if (state_i != SNT) next_o = bp_cnt_e'(state_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch-side lookup is combinational. Execute-side updates are written at the
// clock edge, so a lookup that hits the same entry in the same cycle sees the
// old contents.
// Optional feature: define BP_STATS_EN to enable the UpdateCnt/MissCnt
// statistics counters. Without it, both outputs are tied to 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   PCF                 fetch PC to look up
//   PredTakenF          predicted taken for PCF
//   PredTargetF         predicted target for PCF (0 on miss)
//   UpdateE             branch/jump resolved in Execute this cycle
//   PCE, TakenE         resolved PC and actual outcome
//   PCTargetE           actual target
//   PredTakenE          prediction that was made for PCE in Fetch
//   UpdateCnt, MissCnt  saturating update / mispredict counts
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            UpdateE,
  input  logic [XLEN-1:0] PCE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PredTakenE,
  output logic [31:0]     UpdateCnt,
  output logic [31:0]     MissCnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  bp_cnt_e             cnt_q    [ENTRIES];

  // Fetch lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[XLEN-1:IDX_W+2];
  // Gating with rst keeps outputs quiet while the table is being cleared.
  assign hit_f = !rst && valid_q[idx_f] && (tag_q[idx_f] == tag_f);

  assign PredTakenF  = hit_f && cnt_q[idx_f][1];
  assign PredTargetF = hit_f ? target_q[idx_f] : '0;

  // Execute update
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  bp_cnt_e          cnt_next;
  bp_cnt_e          cnt_d;

  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[XLEN-1:IDX_W+2];
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  bp_sat_counter u_sat (
    .state_i (cnt_q[idx_e]),
    .taken_i (TakenE),
    .next_o  (cnt_next)
  );

  // A fresh allocation starts weak in the observed direction.
  assign cnt_d = hit_e ? cnt_next : (TakenE ? WT : WNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= WNT;
      end
    end else if (UpdateE) begin
      valid_q[idx_e] <= 1'b1;
      cnt_q[idx_e]   <= cnt_d;
    end
  end

  // Tag and target need no reset: valid_q qualifies every read.
  always_ff @(posedge clk) begin
    if (!rst && UpdateE) begin
      tag_q[idx_e] <= tag_e;
      // A not-taken hit keeps its learned target; a not-taken allocation clears it.
      if (TakenE)      target_q[idx_e] <= PCTargetE;
      else if (!hit_e) target_q[idx_e] <= '0;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] upd_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (UpdateE) begin
      if (upd_cnt_q != '1) upd_cnt_q <= upd_cnt_q + 32'd1;
      if ((PredTakenE != TakenE) && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign UpdateCnt = upd_cnt_q;
  assign MissCnt   = miss_cnt_q;

  logic unused_pc;
  assign unused_pc = ^{PCF[1:0], PCE[1:0]};
`else
  assign UpdateCnt = '0;
  assign MissCnt   = '0;

  logic unused_pc;
  assign unused_pc = ^{PCF[1:0], PCE[1:0], PredTakenE};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default XLEN=32, ENTRIES=64).
// Expected results are queued when stimulus is applied and popped for checking.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE;
  logic [31:0] PCE;
  logic        TakenE;
  logic [31:0] PCTargetE;
  logic        PredTakenE;
  logic [31:0] UpdateCnt;
  logic [31:0] MissCnt;

  branch_predictor #(.XLEN(32), .ENTRIES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .UpdateE     (UpdateE),
    .PCE         (PCE),
    .TakenE      (TakenE),
    .PCTargetE   (PCTargetE),
    .PredTakenE  (PredTakenE),
    .UpdateCnt   (UpdateCnt),
    .MissCnt     (MissCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_upd = 0;
  int   n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply PCF, queue the expectation, then pop and compare after settling.
  task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    exp_t e;
    PCF = pc;
    q.push_back('{tag, tk, tgt});
    #1;
    e = q.pop_front();
    chk({e.tag, ".taken"}, {31'd0, PredTakenF}, {31'd0, e.tk});
    chk({e.tag, ".target"}, PredTargetF, e.tgt);
  endtask

  // One-cycle update; returns at the following negedge with UpdateE low.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic ptk);
    @(negedge clk);
    UpdateE = 1'b1; PCE = pc; TakenE = tk; PCTargetE = tgt; PredTakenE = ptk;
    n_upd++;
    if (ptk != tk) n_miss++;
    @(negedge clk);
    UpdateE = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_u, exp_m;
    // Reset with an update pending: it must be ignored.
    rst = 1'b1; UpdateE = 1'b1; PCE = 32'h10; TakenE = 1'b1;
    PCTargetE = 32'h40; PredTakenE = 1'b0; PCF = 32'h10;
    @(negedge clk); @(negedge clk);
    look("in_reset", 32'h10, 1'b0, 32'h0);
    rst = 1'b0; UpdateE = 1'b0;
    look("post_reset_miss", 32'h10, 1'b0, 32'h0);
    chk("reset_updcnt", UpdateCnt, 32'h0);
    chk("reset_misscnt", MissCnt, 32'h0);

    // Allocate taken -> WT
    upd(32'h10, 1'b1, 32'h40, 1'b0);
    look("alloc_taken_wt", 32'h10, 1'b1, 32'h40);
    upd(32'h10, 1'b1, 32'h40, 1'b1);   // ST
    upd(32'h10, 1'b0, 32'h0, 1'b1);    // WT
    look("st_to_wt", 32'h10, 1'b1, 32'h40);
    upd(32'h10, 1'b0, 32'h0, 1'b1);    // WNT
    look("wt_to_wnt", 32'h10, 1'b0, 32'h40);
    upd(32'h10, 1'b0, 32'h0, 1'b0);    // SNT
    upd(32'h10, 1'b0, 32'h0, 1'b0);    // stays SNT
    upd(32'h10, 1'b1, 32'h40, 1'b0);   // WNT only if SNT held
    look("snt_saturates", 32'h10, 1'b0, 32'h40);
    upd(32'h10, 1'b1, 32'h40, 1'b0);   // WT
    look("wnt_to_wt", 32'h10, 1'b1, 32'h40);

    // Same index, different tag replaces the entry.
    upd(32'h110, 1'b1, 32'h80, 1'b0);
    look("alias_old_miss", 32'h10, 1'b0, 32'h0);
    look("alias_new_hit", 32'h110, 1'b1, 32'h80);

    // Not-taken allocation: WNT with zero target, then one taken -> WT.
    upd(32'h210, 1'b0, 32'h777, 1'b0);
    look("alloc_nt", 32'h210, 1'b0, 32'h0);
    upd(32'h210, 1'b1, 32'h99c, 1'b0);
    look("alloc_nt_then_t", 32'h210, 1'b1, 32'h99c);

    // Same-cycle lookup/update returns pre-update state.
    @(negedge clk);
    UpdateE = 1'b1; PCE = 32'h20; TakenE = 1'b1; PCTargetE = 32'h123; PredTakenE = 1'b0;
    n_upd++; n_miss++;
    look("same_cycle_old", 32'h20, 1'b0, 32'h0);
    @(negedge clk);
    UpdateE = 1'b0;
    look("same_cycle_next", 32'h20, 1'b1, 32'h123);
    look("pc_low_bits_ignored", 32'h22, 1'b1, 32'h123);

    // Statistics
`ifdef BP_STATS_EN
    exp_u = n_upd; exp_m = n_miss;
`else
    exp_u = 32'h0; exp_m = 32'h0;
`endif
    chk("updcnt", UpdateCnt, exp_u);
    chk("misscnt", MissCnt, exp_m);

    // Mid-operation reset discards everything.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_updcnt", UpdateCnt, 32'h0);
    chk("rst_misscnt", MissCnt, 32'h0);
    look("rst_forgets_20", 32'h20, 1'b0, 32'h0);
    look("rst_forgets_110", 32'h110, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
